// File: rtl/imem_loader.sv
// Framed byte-stream loader for the instruction memory.
// Parses sync/address/length/data/checksum frames into byte writes.
module imem_loader #(
  parameter int MEM_SIZE = 1024,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              load_error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR0,
    S_ADDR1,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_FLUSH,
    S_CHK,
    S_DONE
  } state_t;

  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam logic [16:0] MEM_LIM = 17'(MEM_SIZE);

  state_t            state_q, state_d;
  logic [15:0]       addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [7:0]        acc_q, acc_d;
  logic              rerr_q, rerr_d;
  logic              lerr_q, lerr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              take;
  logic [15:0]       len_w;
  logic [16:0]       end_w;
  logic [15:0]       cnt_inc;
  logic              last;

  assign in_ready   = (state_q != S_DONE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign load_error = lerr_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;

  assign take    = in_valid && in_ready;
  assign len_w   = {in_data, len_q[7:0]};
  // 17-bit sum so an end past 64K cannot wrap into range
  assign end_w   = {1'b0, addr_q} + {1'b0, len_w};
  assign cnt_inc = cnt_q + 16'd1;
  assign last    = (cnt_inc == len_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rerr_d    = rerr_q;
    lerr_d    = lerr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (take) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_data == SYNC) begin
            state_d = S_ADDR0;
            lerr_d  = 1'b0;
            rerr_d  = 1'b0;
            acc_d   = 8'h00;
          end
        end
        S_ADDR0: begin
          addr_d[7:0] = in_data;
          state_d     = S_ADDR1;
        end
        S_ADDR1: begin
          addr_d[15:8] = in_data;
          state_d      = S_LEN0;
        end
        S_LEN0: begin
          len_d[7:0] = in_data;
          state_d    = S_LEN1;
        end
        S_LEN1: begin
          len_d[15:8] = in_data;
          cnt_d       = 16'd0;
          if (end_w > MEM_LIM) begin
            rerr_d  = 1'b1;
            state_d = (len_w == 16'd0) ? S_CHK : S_FLUSH;
          end else if (len_w == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_data_d = in_data;
          wr_addr_d = addr_q[ADDR_W-1:0] + cnt_q[ADDR_W-1:0];
          acc_d     = acc_q ^ in_data;
          cnt_d     = cnt_inc;
          if (last) state_d = S_CHK;
        end
        S_FLUSH: begin
          cnt_d = cnt_inc;
          if (last) state_d = S_CHK;
        end
        S_CHK: begin
          lerr_d  = rerr_q || (in_data != acc_q);
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      rerr_q    <= 1'b0;
      lerr_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rerr_q    <= rerr_d;
      lerr_q    <= lerr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

endmodule
